wb_mac_array: RTL and testbench
===============================

# wb_mac_array

Wishbone-attached, multi-lane multiply-accumulate engine for the user project area. It is the parametrised successor of the single-MAC user project and sits directly behind the user_project_wrapper Wishbone port. The host writes packed operand vectors. Each B-vector write issues one pipelined MAC across all lanes. Completion of a programmed vector length raises an interrupt.

## Interface
Parameters:
- LANES, 4: number of parallel MAC lanes; LANES*DATA_W ≤ 32.
- DATA_W, 8: operand element width.
- ACC_W, 32: accumulator width per lane; ACC_W ≤ 32 and ACC_W ≥ 2*DATA_W.
- BASE_ADDR, 32'h3000_0000: block base; decode on wbs_adr_i[31:8].

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- irq  out  3  irq[0] = done interrupt; irq[2:1] tied 0.

## Operation
Register map, offsets from BASE_ADDR:
- 0x00 CTRL, RW: bit0 CLEAR (self-clearing, reads 0), bit1 SIGNED, bit2 SAT, bit3 IRQ_EN.
- 0x04 STATUS: bit0 BUSY (RO), bit1 DONE (W1C), bit2 OVF (sticky, W1C).
- 0x08 LEN, RW, 16 bit: number of MAC issues that sets DONE.
- 0x0C A, RW: lane i operand = bits [i*DATA_W +: DATA_W].
- 0x10 B, RW: same packing. Any write here issues one MAC.
- 0x14 COUNT, RO, 16 bit: MACs completed since last CLEAR.
- 0x20+4*i ACC[i], RO: lane i accumulator, zero-extended to 32 bits. Holds 0 for i ≥ LANES.
- Unmapped offsets: reads return 0; writes are ignored but still acknowledged.

Writes and lanes:
- Byte selects apply to CTRL, LEN, A and B.
- A B write with partial sel merges the new bytes with the old B bytes, then still issues.
- Each lane computes acc ± a*b. SIGNED selects two's-complement operands and product; otherwise operands are unsigned.
- Overflow, SIGNED: result exceeds the ACC_W signed range. Unsigned: carry out of ACC_W.
- On overflow, OVF is set. With SAT=1 the result clamps to max/min (signed) or all-ones (unsigned). With SAT=0 it wraps.

Counting and interrupt:
- COUNT increments once per completed issue and wraps at 16 bits.
- DONE sets on the edge COUNT becomes equal to LEN. LEN=0 never sets DONE.
- irq[0] = DONE & IRQ_EN, registered.

CLEAR:
- Zeroes all ACC, COUNT, DONE and OVF.
- Discards any in-flight issue.
- If a B write and CLEAR land in the same cycle, CLEAR wins and the issue is dropped.

## Timing
- Reset values: wbs_ack_o=0, wbs_dat_o=0, irq=0, and all registers 0. Reset mid-pipeline drops every in-flight issue.
- Handshake:
  - A request is cyc&stb&~ack.
  - The request is sampled at edge E. wbs_ack_o is high for exactly one cycle after E.
  - Read data is valid in the ack cycle.
  - Back-to-back requests are allowed: at most one ack per two cycles per held strobe.
- Pipeline for a B write sampled at edge E:
  - E: operands latched, BUSY=1.
  - E+1: products registered.
  - E+2: ACC, COUNT, DONE and OVF update.
  - BUSY clears after E+2 unless another issue is in flight.
  - Issue-to-ACC-visible latency is 2 cycles. Throughput is one issue per ack.
- irq[0] rises one cycle after DONE sets. It falls one cycle after the W1C write to DONE or after IRQ_EN is cleared.
- Reading ACC during BUSY returns the pre-update value. No stall is applied.

## Test plan
- Reset: hold wb_rst_i 2 cycles → wbs_ack_o=0, irq=0, and reads of all registers return 0.
- Unsigned dot product:
  - Setup: LEN=3, IRQ_EN=1; A=0x04030201.
  - Stimulus: three writes B=0x01010101.
  - Expected: ACC[0..3]=3,6,9,12; COUNT=3; DONE=1; irq[0]=1 one cycle after DONE sets. W1C on DONE drops irq.
- Signed with saturation:
  - Setup: SIGNED=1, SAT=1, ACC_W=16 build; A=0x7F in every lane, B=0x7F in every lane.
  - Stimulus: 3 issues.
  - Expected: ACC=32767 (clamped); OVF=1.
- Wrap without saturation: same stimulus with SAT=0 → ACC=(3*16129) mod 65536 = 48387 read as raw bits; OVF=1.
- CLEAR collision: CLEAR written in the same cycle a B write is sampled, with one issue already in flight → ACC=0, COUNT=0, and neither issue takes effect.
- Byte selects and unmapped: B write with sel=4'b0001 updates lane 0 only and still issues. Read of 0x40 returns 0 and is acknowledged in one cycle.

Source files
------------

// File: rtl/wb_mac_array.sv
// rtl/wb_mac_array.sv - Wishbone multi-lane multiply-accumulate engine
// Each B write issues a 2-stage MAC across all lanes; DONE fires when COUNT reaches LEN.
module wb_mac_array #(
  parameter int          LANES     = 4,
  parameter int          DATA_W    = 8,
  parameter int          ACC_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [2:0]  irq
);

  localparam int PW = 2 * DATA_W;
  localparam int SW = ACC_W + 2;
  localparam int VW = LANES * DATA_W;

  logic              ctrl_signed, ctrl_sat, ctrl_irq_en;
  logic              done, ovf, irq_q;
  logic [15:0]       len, count;
  logic [31:0]       a_reg, b_reg;
  logic [VW-1:0]     op_a, op_b;
  logic              v0, v1, sgn1;
  logic [PW-1:0]     prod   [LANES];
  logic [PW-1:0]     prod_n [LANES];
  logic [ACC_W-1:0]  acc    [LANES];
  logic [ACC_W-1:0]  res    [LANES];
  logic [LANES-1:0]  lane_ovf;
  logic [31:0]       rd_data, b_merged;
  logic [SW-1:0]     ae, pe, s;
  logic [2:0]        hi;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] sel);
    for (int k = 0; k < 4; k++)
      merge[k*8 +: 8] = sel[k] ? new_v[k*8 +: 8] : old_v[k*8 +: 8];
  endfunction

  wire       req   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  wire       hit   = wbs_adr_i[31:8] == BASE_ADDR[31:8];
  wire [7:0] off   = wbs_adr_i[7:0];
  wire       wr    = req & hit & wbs_we_i;
  wire       issue = wr & (off == 8'h10);
  wire       clear = wr & (off == 8'h00) & wbs_sel_i[0] & wbs_dat_i[0];
  wire       busy  = v0 | v1;

  assign b_merged = merge(b_reg, wbs_dat_i, wbs_sel_i);
  assign irq      = {2'b00, irq_q};

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (ctrl_signed)
        prod_n[i] = $signed({{DATA_W{op_a[i*DATA_W+DATA_W-1]}}, op_a[i*DATA_W +: DATA_W]}) *
                    $signed({{DATA_W{op_b[i*DATA_W+DATA_W-1]}}, op_b[i*DATA_W +: DATA_W]});
      else
        prod_n[i] = {{DATA_W{1'b0}}, op_a[i*DATA_W +: DATA_W]} *
                    {{DATA_W{1'b0}}, op_b[i*DATA_W +: DATA_W]};
    end
  end

  // Sum in ACC_W+2 bits so the true sign/carry survives for overflow and clamping.
  always_comb begin
    ae = '0;
    pe = '0;
    s  = '0;
    hi = '0;
    for (int i = 0; i < LANES; i++) begin
      ae = sgn1 ? {{2{acc[i][ACC_W-1]}}, acc[i]} : {2'b00, acc[i]};
      pe = sgn1 ? {{(SW-PW){prod[i][PW-1]}}, prod[i]} : {{(SW-PW){1'b0}}, prod[i]};
      s  = ae + pe;
      hi = s[SW-1:ACC_W-1];
      res[i] = s[ACC_W-1:0];
      if (sgn1) begin
        lane_ovf[i] = (hi != 3'b000) && (hi != 3'b111);
        if (lane_ovf[i] && ctrl_sat)
          res[i] = s[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        lane_ovf[i] = s[ACC_W];
        if (lane_ovf[i] && ctrl_sat)
          res[i] = '1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (hit) begin
      case (off)
        8'h00:   rd_data = {28'd0, ctrl_irq_en, ctrl_sat, ctrl_signed, 1'b0};
        8'h04:   rd_data = {29'd0, ovf, done, busy};
        8'h08:   rd_data = {16'd0, len};
        8'h0C:   rd_data = a_reg;
        8'h10:   rd_data = b_reg;
        8'h14:   rd_data = {16'd0, count};
        default: begin
          for (int i = 0; i < LANES; i++)
            if (off == 8'(32 + 4 * i)) rd_data = 32'(acc[i]);
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= '0;
      irq_q       <= 1'b0;
      ctrl_signed <= 1'b0;
      ctrl_sat    <= 1'b0;
      ctrl_irq_en <= 1'b0;
      done        <= 1'b0;
      ovf         <= 1'b0;
      len         <= '0;
      count       <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      op_a        <= '0;
      op_b        <= '0;
      v0          <= 1'b0;
      v1          <= 1'b0;
      sgn1        <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        prod[i] <= '0;
        acc[i]  <= '0;
      end
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req & ~wbs_we_i) ? rd_data : 32'd0;
      irq_q     <= done & ctrl_irq_en;

      if (wr && off == 8'h00 && wbs_sel_i[0])
        {ctrl_irq_en, ctrl_sat, ctrl_signed} <= wbs_dat_i[3:1];
      if (wr && off == 8'h08)
        len <= 16'(merge({16'd0, len}, wbs_dat_i, wbs_sel_i));
      if (wr && off == 8'h0C)
        a_reg <= merge(a_reg, wbs_dat_i, wbs_sel_i);
      if (issue) begin
        b_reg <= b_merged;
        op_a  <= a_reg[VW-1:0];
        op_b  <= b_merged[VW-1:0];
      end
      v0 <= issue;

      v1   <= v0;
      sgn1 <= ctrl_signed;
      if (v0)
        for (int i = 0; i < LANES; i++) prod[i] <= prod_n[i];

      // W1C comes before the pipeline update so a same-edge completion still sets the flag.
      if (wr && off == 8'h04 && wbs_sel_i[0]) begin
        if (wbs_dat_i[1]) done <= 1'b0;
        if (wbs_dat_i[2]) ovf  <= 1'b0;
      end
      if (v1) begin
        for (int i = 0; i < LANES; i++) acc[i] <= res[i];
        count <= count + 16'd1;
        if (len != 16'd0 && count + 16'd1 == len) done <= 1'b1;
        if (|lane_ovf) ovf <= 1'b1;
      end

      if (clear) begin
        for (int i = 0; i < LANES; i++) acc[i] <= '0;
        count <= '0;
        done  <= 1'b0;
        ovf   <= 1'b0;
        v0    <= 1'b0;
        v1    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_mac_array.sv
// tb/tb_wb_mac_array.sv - directed self-checking bench for wb_mac_array (ACC_W=16 build)
module tb_wb_mac_array;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat_w = '0;
  logic        ack;
  logic [31:0] dat_r;
  logic [2:0]  irq;

  int checks = 0;
  int failures = 0;
  logic [31:0] rv;
  int lat;

  wb_mac_array #(.LANES(4), .DATA_W(8), .ACC_W(16), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack),
    .wbs_dat_o(dat_r), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 16);
    if (!ack) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic xfer(input logic w, input logic [7:0] off, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rdata, output int n);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = BASE | {24'd0, off}; dat_w = d; sel = s;
    wait_ack(n);
    rdata = dat_r;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] r;
    int n;
    xfer(1'b1, off, d, 4'hF, r, n);
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] r);
    int n;
    xfer(1'b0, off, 32'd0, 4'hF, r, n);
  endtask

  logic [7:0] reg_offs [10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14,
                                8'h20, 8'h24, 8'h28, 8'h2C};
  logic [31:0] dot_exp [4] = '{32'd3, 32'd6, 32'd9, 32'd12};

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_irq", {29'd0, irq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    foreach (reg_offs[k]) begin
      rd(reg_offs[k], rv);
      check($sformatf("rst_reg_%02h", reg_offs[k]), rv, 32'd0);
    end

    // unsigned dot product
    wr(8'h08, 32'd3);
    wr(8'h00, 32'h8);
    wr(8'h0C, 32'h0403_0201);
    wr(8'h10, 32'h0101_0101);
    wr(8'h10, 32'h0101_0101);
    wr(8'h10, 32'h0101_0101);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("irq_lag", {29'd0, irq}, 32'd0);
    @(posedge clk); #1;
    check("irq_rise", {29'd0, irq}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      rd(8'(32 + 4 * i), rv);
      check($sformatf("dot_acc%0d", i), rv, dot_exp[i]);
    end
    rd(8'h14, rv);
    check("dot_count", rv, 32'd3);
    rd(8'h04, rv);
    check("dot_status", rv, 32'h2);
    wr(8'h04, 32'h2);
    @(posedge clk); #1;
    check("irq_fall", {29'd0, irq}, 32'd0);
    rd(8'h04, rv);
    check("w1c_status", rv, 32'h0);

    // signed saturation: 3 x 127*127 = 48387 exceeds 32767
    wr(8'h00, 32'h7);
    wr(8'h0C, 32'h7F7F_7F7F);
    wr(8'h10, 32'h7F7F_7F7F);
    rd(8'h04, rv);
    check("busy", rv, 32'h1);
    wr(8'h10, 32'h7F7F_7F7F);
    wr(8'h10, 32'h7F7F_7F7F);
    repeat (4) @(posedge clk);
    rd(8'h20, rv);
    check("sat_acc0", rv, 32'd32767);
    rd(8'h2C, rv);
    check("sat_acc3", rv, 32'd32767);
    rd(8'h04, rv);
    check("sat_status", rv, 32'h6);

    // signed wrap
    wr(8'h00, 32'h3);
    rd(8'h04, rv);
    check("clear_status", rv, 32'h0);
    for (int k = 0; k < 3; k++) wr(8'h10, 32'h7F7F_7F7F);
    repeat (4) @(posedge clk);
    rd(8'h20, rv);
    check("wrap_acc0", rv, 32'd48387);
    rd(8'h28, rv);
    check("wrap_acc2", rv, 32'd48387);
    rd(8'h04, rv);
    check("wrap_status", rv, 32'h6);

    // CLEAR lands on the edge the in-flight issue would commit
    wr(8'h00, 32'h1);
    wr(8'h0C, 32'h0403_0201);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
    adr = BASE | 32'h10; dat_w = 32'h0101_0101;
    wait_ack(lat);
    @(negedge clk);
    adr = BASE; dat_w = 32'h1;
    wait_ack(lat);
    check("b2b_lat", lat, 32'd2);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (4) @(posedge clk);
    rd(8'h20, rv);
    check("coll_acc0", rv, 32'd0);
    rd(8'h14, rv);
    check("coll_count", rv, 32'd0);

    // byte-select merge on B
    xfer(1'b1, 8'h10, 32'h0000_0005, 4'b0001, rv, lat);
    repeat (4) @(posedge clk);
    rd(8'h10, rv);
    check("sel_b", rv, 32'h0101_0105);
    rd(8'h20, rv);
    check("sel_acc0", rv, 32'd5);
    rd(8'h24, rv);
    check("sel_acc1", rv, 32'd2);
    rd(8'h14, rv);
    check("sel_count", rv, 32'd1);

    // unmapped and beyond-lane reads
    xfer(1'b0, 8'h40, 32'd0, 4'hF, rv, lat);
    check("unmapped_rd", rv, 32'd0);
    check("unmapped_lat", lat, 32'd1);
    @(posedge clk); #1;
    check("ack_pulse", {31'd0, ack}, 32'd0);
    xfer(1'b1, 8'h18, 32'hFFFF_FFFF, 4'hF, rv, lat);
    check("unmapped_wr_lat", lat, 32'd1);
    rd(8'h30, rv);
    check("acc_lane4", rv, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
